muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits beside the ALU in the execute stage. The decoder issues MULT/MULTU/DIV/DIVU (funct 011000/011001/011010/011011) through a start pulse. MFHI/MFLO read `hi`/`lo` directly, and the core stalls them while `busy` is high. One radix-2 shift/add-subtract step per cycle is shared by multiply and divide, sequenced by a small FSM.

---
 rtl/muldiv_pkg.sv | 56 +++++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Purpose : shared encodings, FSM state type and sign helpers for the multiply/divide unit.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

  // Helpers operate on a fixed wide vector so one definition serves any unit
  // width. Callers zero-extend into it and keep the low bits they need. The
  // unit uses the low 2*WIDTH bits, which supports WIDTH up to 63.
  localparam int MD_MAX_W = 128;
  typedef logic [MD_MAX_W-1:0] md_wide_t;

  // Bit 1 selects divide and bit 0 selects unsigned, so the datapath can
  // decode the op straight from these two bits.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // SPECIAL-opcode funct codes, used by the decoder to form `op`.
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  function automatic logic [1:0] md_funct_to_op(input logic [5:0] funct);
    logic [1:0] op;
    op = OP_MULT;
    case (funct)
      FUNCT_MULT:  op = OP_MULT;
      FUNCT_MULTU: op = OP_MULTU;
      FUNCT_DIV:   op = OP_DIV;
      FUNCT_DIVU:  op = OP_DIVU;
      default:     op = OP_MULT;
    endcase
    return op;
  endfunction

  // Two's-complement negate. The low w bits of the result are the w-bit
  // negation of the low w bits of x.
  function automatic md_wide_t md_neg(input md_wide_t x);
    return ~x + md_wide_t'(1);
  endfunction

  // Magnitude of a w-bit signed value held zero-extended in x.
  // The most negative value maps to itself, which reads correctly as unsigned.
  function automatic md_wide_t md_abs(input md_wide_t x, input int w);
    return x[w-1] ? md_neg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Purpose : issue / HI-LO bus between the execute stage and the multiply/divide unit.
// Latency : n/a (wires only).
// Backpressure: none on the bus. The core stalls on `busy` and must not issue while it is high.
// Ports   : master = core side (drives issue and MTHI/MTLO), slave = unit side (drives status and HI/LO).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi_en;
  logic             mtlo_en;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mthi_en, mtlo_en, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi_en, mtlo_en, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// Purpose : one radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_is_div selects divide; i_bit is the next multiplier bit or dividend bit (MSB first);
//           i_a is the multiplicand; i_b is the divisor; i_acc is the current accumulator; o_acc is the next.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic               i_bit,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;

  // Multiply walks the multiplier MSB-first: acc = 2*acc + (bit ? a : 0).
  assign w_mul_acc = {i_acc[2*WIDTH-2:0], 1'b0} + (i_bit ? {{WIDTH{1'b0}}, i_a} : '0);

  // Divide: remainder lives in the upper half and the quotient shifts in at the
  // bottom. The remainder is always below the divisor, so one extra bit is
  // enough for the trial subtract, and bit WIDTH of the result is the borrow.
  assign w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_bit};
  assign w_trial  = w_rem_sh - {1'b0, i_b};

  always_comb begin
    o_acc = w_mul_acc;
    if (i_is_div) begin
      if (!w_trial[WIDTH]) begin
        o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Latency : WIDTH+1 edges from the start edge to the HI/LO update; `done` pulses in the following cycle.
// Backpressure: start is ignored while busy (no queueing); MTHI/MTLO are dropped while busy.
// Ports   : i_clk, i_rst_n (async, active low); md_if slave modport carries issue, MTHI/MTLO, busy/done/div_by_zero, hi/lo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  muldiv_if.slave md_if
);
  localparam int CW = $clog2(WIDTH);

  md_state_t          r_state;
  md_state_t          w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic               r_done;
  logic               r_dbz_pulse;
  logic               w_signed;
  logic               w_step_bit;
  md_wide_t           w_rs_abs;
  md_wide_t           w_rt_abs;
  md_wide_t           w_prod_neg;
  md_wide_t           w_quo_neg;
  md_wide_t           w_rem_neg;
  logic               w_unused;

  assign w_signed = ~md_if.op[0];
  assign w_rs_abs = md_abs(md_wide_t'(md_if.rs_val), WIDTH);
  assign w_rt_abs = md_abs(md_wide_t'(md_if.rt_val), WIDTH);

  // Only the low bits of the wide helper results are meaningful.
  assign w_unused = ^{w_rs_abs[MD_MAX_W-1:WIDTH], w_rt_abs[MD_MAX_W-1:WIDTH],
                      w_prod_neg[MD_MAX_W-1:2*WIDTH], w_quo_neg[MD_MAX_W-1:WIDTH],
                      w_rem_neg[MD_MAX_W-1:WIDTH]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (md_if.start) w_state_nxt = RUN;
      RUN:     if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // Divide feeds dividend bits into the remainder; multiply scans multiplier bits.
  assign w_step_bit = r_is_div ? r_a[r_cnt] : r_b[r_cnt];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_bit    (w_step_bit),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_acc    (r_acc),
    .o_acc    (w_step_acc)
  );

  assign w_prod_neg = md_neg(md_wide_t'(r_acc));
  assign w_quo_neg  = md_neg(md_wide_t'(r_acc[WIDTH-1:0]));
  assign w_rem_neg  = md_neg(md_wide_t'(r_acc[2*WIDTH-1:WIDTH]));

  // Sign correction. For divide by zero the restoring loop naturally leaves
  // |rs| as remainder, so re-applying the dividend sign recovers rs as issued;
  // only the quotient has to be forced.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (!r_is_div) begin
      if (r_neg_q) {w_fix_hi, w_fix_lo} = w_prod_neg[2*WIDTH-1:0];
    end else begin
      if (r_neg_q) w_fix_lo = w_quo_neg[WIDTH-1:0];
      if (r_neg_r) w_fix_hi = w_rem_neg[WIDTH-1:0];
      if (r_dbz)   w_fix_lo = '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (md_if.mthi_en) r_hi <= md_if.wdata;
          if (md_if.mtlo_en) r_lo <= md_if.wdata;
          if (md_if.start) begin
            r_is_div <= md_if.op[1];
            r_a      <= w_signed ? w_rs_abs[WIDTH-1:0] : md_if.rs_val;
            r_b      <= w_signed ? w_rt_abs[WIDTH-1:0] : md_if.rt_val;
            r_neg_q  <= w_signed & (md_if.rs_val[WIDTH-1] ^ md_if.rt_val[WIDTH-1]);
            r_neg_r  <= w_signed & md_if.rs_val[WIDTH-1];
            r_dbz    <= md_if.op[1] & (md_if.rt_val == '0);
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_hi        <= w_fix_hi;
          r_lo        <= w_fix_lo;
          r_done      <= 1'b1;
          r_dbz_pulse <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign md_if.busy        = (r_state != IDLE);
  assign md_if.done        = r_done;
  assign md_if.div_by_zero = r_dbz_pulse;
  assign md_if.hi          = r_hi;
  assign md_if.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose : self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
// Latency : expects WIDTH+1 busy cycles per op and a one-cycle done pulse.
// Backpressure: issues only when idle, except the deliberate start-while-busy case.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) md_if ();

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .md_if   (md_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic. SV signed '/' and '%' truncate toward
  // zero with the remainder taking the dividend sign, matching MIPS.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    if (op[1] && b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else begin
      case (op)
        OP_MULT:  begin sp = sa * sb; {hi, lo} = sp; end
        OP_MULTU: begin up = ua * ub; {hi, lo} = up; end
        OP_DIV:   begin sq = sa / sb; sr = sa % sb; lo = 32'(sq); hi = 32'(sr); end
        default:  begin uq = ua / ub; ur = ua % ub; lo = 32'(uq); hi = 32'(ur); end
      endcase
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic idle_inputs();
    md_if.start   = 1'b0;
    md_if.op      = 2'b00;
    md_if.rs_val  = '0;
    md_if.rt_val  = '0;
    md_if.mthi_en = 1'b0;
    md_if.mtlo_en = 1'b0;
    md_if.wdata   = '0;
  endtask

  // Called at a negedge; holds start for exactly one edge, then scrambles the
  // operands so the unit must have latched them on the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start  = 1'b1;
    md_if.op     = op;
    md_if.rs_val = a;
    md_if.rt_val = b;
    @(negedge clk);
    md_if.start  = 1'b0;
    md_if.op     = 2'($urandom());
    md_if.rs_val = 32'($urandom());
    md_if.rt_val = 32'($urandom());
  endtask

  // Returns at the negedge where done is seen; counts busy cycles on the way
  // and checks that HI/LO hold still until the update.
  task automatic wait_done(input string tag, output int busy_cyc);
    logic [31:0] hi0, lo0;
    logic        moved;
    int          n;
    busy_cyc = 0;
    moved    = 1'b0;
    n        = 0;
    hi0      = md_if.hi;
    lo0      = md_if.lo;
    while (md_if.done !== 1'b1 && n < 200) begin
      if (md_if.busy === 1'b1) busy_cyc++;
      if (md_if.hi !== hi0 || md_if.lo !== lo0) moved = 1'b1;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_timeout"}, 32'(n >= 200), 32'd0);
    check_eq({tag, "_hilo_stable"}, 32'(moved), 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int bc;
    issue(op, a, b);
    wait_done(tag, bc);
    check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(W + 1));
    check_eq({tag, "_busy_on_done"}, 32'(md_if.busy), 32'd0);
    check_eq({tag, "_hi"}, md_if.hi, exp_hi);
    check_eq({tag, "_lo"}, md_if.lo, exp_lo);
    check_eq({tag, "_dbz"}, 32'(md_if.div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(md_if.done), 32'd0);
    check_eq({tag, "_dbz_one_cycle"}, 32'(md_if.div_by_zero), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_hi, e_lo, a, b, lo_before;
    logic        e_dbz;
    logic [1:0]  op;
    int          bc;

    idle_inputs();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(md_if.busy), 32'd0);
    check_eq("rst_done", 32'(md_if.done), 32'd0);
    check_eq("rst_dbz", 32'(md_if.div_by_zero), 32'd0);
    check_eq("rst_hi", md_if.hi, 32'd0);
    check_eq("rst_lo", md_if.lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results.
    run_check("multu_4x7", md_funct_to_op(FUNCT_MULTU), 32'd4, 32'd7, 32'd0, 32'd28, 1'b0);
    run_check("mult_m3x5", md_funct_to_op(FUNCT_MULT), 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_check("mult_minsq", md_funct_to_op(FUNCT_MULT), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    run_check("divu_100_7", md_funct_to_op(FUNCT_DIVU), 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_check("div_m7_2", md_funct_to_op(FUNCT_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_ovf", md_funct_to_op(FUNCT_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_check("div_9_0", md_funct_to_op(FUNCT_DIV), 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
    run_check("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // MTHI and MTLO together in IDLE.
    md_if.mthi_en = 1'b1;
    md_if.mtlo_en = 1'b1;
    md_if.wdata   = 32'hA5A5_5A5A;
    @(negedge clk);
    md_if.mthi_en = 1'b0;
    md_if.mtlo_en = 1'b0;
    check_eq("mt_both_hi", md_if.hi, 32'hA5A5_5A5A);
    check_eq("mt_both_lo", md_if.lo, 32'hA5A5_5A5A);

    // MTHI on the start cycle lands, then the result overwrites it.
    md_if.mthi_en = 1'b1;
    md_if.wdata   = 32'h1234_5678;
    issue(OP_MULTU, 32'd3, 32'd3);
    md_if.mthi_en = 1'b0;
    check_eq("mthi_with_start", md_if.hi, 32'h1234_5678);
    wait_done("mthi_start_op", bc);
    check_eq("mthi_start_op_hi", md_if.hi, 32'd0);
    check_eq("mthi_start_op_lo", md_if.lo, 32'd9);
    @(negedge clk);

    // Second start mid-operation is ignored; MTLO while busy is dropped.
    ref_model(OP_MULT, 32'd1234, 32'hFFFF_FFC8, e_hi, e_lo, e_dbz);
    issue(OP_MULT, 32'd1234, 32'hFFFF_FFC8);
    repeat (9) @(negedge clk);
    md_if.start  = 1'b1;
    md_if.op     = OP_DIVU;
    md_if.rs_val = 32'd77;
    md_if.rt_val = 32'd0;
    @(negedge clk);
    md_if.start   = 1'b0;
    lo_before     = md_if.lo;
    md_if.mtlo_en = 1'b1;
    md_if.wdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    md_if.mtlo_en = 1'b0;
    check_eq("mtlo_busy_dropped", md_if.lo, lo_before);
    wait_done("ignored_start", bc);
    check_eq("ignored_start_hi", md_if.hi, e_hi);
    check_eq("ignored_start_lo", md_if.lo, e_lo);
    check_eq("ignored_start_dbz", 32'(md_if.div_by_zero), 32'd0);
    @(negedge clk);
    check_eq("ignored_start_no_rerun", 32'(md_if.busy), 32'd0);

    // Back-to-back: second start on the done cycle.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("b2b_first", bc);
    check_eq("b2b_first_lo", md_if.lo, 32'd14);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check_eq("b2b_second_busy", 32'(md_if.busy), 32'd1);
    wait_done("b2b_second", bc);
    check_eq("b2b_second_cycles", 32'(bc), 32'(W + 1));
    check_eq("b2b_second_hi", md_if.hi, 32'hFFFF_FFFF);
    check_eq("b2b_second_lo", md_if.lo, 32'hFFFF_FFF1);
    @(negedge clk);

    // Reset in the middle of a DIV takes effect without a clock edge.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(md_if.busy), 32'd0);
    check_eq("midrst_done", 32'(md_if.done), 32'd0);
    check_eq("midrst_dbz", 32'(md_if.div_by_zero), 32'd0);
    check_eq("midrst_hi", md_if.hi, 32'd0);
    check_eq("midrst_lo", md_if.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_idle", 32'(md_if.busy), 32'd0);
    run_check("postrst_div", OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_val();
      b  = pick_val();
      ref_model(op, a, b, e_hi, e_lo, e_dbz);
      run_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, e_hi, e_lo, e_dbz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
